// File: rtl/io_bank.sv
// Memory-mapped I/O bank: GPIO, byte TX FIFO and a 32-bit match timer behind a word-addressed register map.
// Reads are combinational in the io_en cycle; writes land on the next edge; TX bytes are dropped (ovf) when full and not draining.
module io_bank #(
    parameter int FIFO_DEPTH     = 8,
    parameter int FIFO_DEPTH_LOG = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  io_addr,
    input  logic        io_en,
    input  logic        io_we,
    input  logic [31:0] io_data_write,
    output logic [31:0] io_data_read,
    input  logic [7:0]  gpio_in,
    output logic [31:0] gpio_out,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        irq
);

    localparam logic [5:0] OFF_GPIO_OUT = 6'h00;
    localparam logic [5:0] OFF_GPIO_IN  = 6'h01;
    localparam logic [5:0] OFF_TX_DATA  = 6'h02;
    localparam logic [5:0] OFF_STATUS   = 6'h03;
    localparam logic [5:0] OFF_TMR_CNT  = 6'h04;
    localparam logic [5:0] OFF_TMR_CMP  = 6'h05;
    localparam logic [5:0] OFF_TMR_CTRL = 6'h06;

    localparam int CW = FIFO_DEPTH_LOG + 1;
    localparam logic [CW-1:0]             CNT_FULL = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0]             CNT_ONE  = CW'(1);
    localparam logic [FIFO_DEPTH_LOG-1:0] PTR_ONE  = FIFO_DEPTH_LOG'(1);

    logic [5:0]  word_sel;
    logic        wr_en;
    logic        unused_addr_lsb;

    logic [7:0]  gpio_sync1;
    logic [7:0]  gpio_sync2;

    logic [7:0]                fifo_mem [FIFO_DEPTH];
    logic [FIFO_DEPTH_LOG-1:0] wr_ptr;
    logic [FIFO_DEPTH_LOG-1:0] rd_ptr;
    logic [CW-1:0]             fifo_cnt;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic                      push_req;
    logic                      push_ok;
    logic                      pop;
    logic                      ovf;

    logic [31:0] tmr_cnt;
    logic [31:0] tmr_cmp;
    logic        tmr_en;
    logic        tmr_clr_on_match;
    logic        tmr_match;
    logic        pending;
    logic [31:0] tmr_cnt_nxt;

    logic [31:0] status;

    assign word_sel        = io_addr[7:2];
    assign wr_en           = io_en & io_we;
    assign unused_addr_lsb = ^io_addr[1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gpio_out <= 32'h0;
        end else if (wr_en && word_sel == OFF_GPIO_OUT) begin
            gpio_out <= io_data_write;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gpio_sync1 <= 8'h0;
            gpio_sync2 <= 8'h0;
        end else begin
            gpio_sync1 <= gpio_in;
            gpio_sync2 <= gpio_sync1;
        end
    end

    assign fifo_full  = (fifo_cnt == CNT_FULL);
    assign fifo_empty = (fifo_cnt == '0);
    assign tx_valid   = ~fifo_empty;
    assign tx_data    = fifo_mem[rd_ptr];
    assign pop        = tx_valid & tx_ready;
    assign push_req   = wr_en && (word_sel == OFF_TX_DATA);
    // A full FIFO still takes a byte when the head leaves on the same edge.
    assign push_ok    = push_req && (!fifo_full || pop);

    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr] <= io_data_write[7:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (push_ok && !pop) begin
                fifo_cnt <= fifo_cnt + CNT_ONE;
            end else if (pop && !push_ok) begin
                fifo_cnt <= fifo_cnt - CNT_ONE;
            end
        end
    end

    // A drop in the same cycle as a software clear keeps ovf set so the loss is not hidden.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf <= 1'b0;
        end else if (push_req && !push_ok) begin
            ovf <= 1'b1;
        end else if (wr_en && word_sel == OFF_STATUS && io_data_write[9]) begin
            ovf <= 1'b0;
        end
    end

    assign tmr_match = tmr_en && (tmr_cnt == tmr_cmp);

    always_comb begin
        tmr_cnt_nxt = tmr_cnt;
        if (tmr_en) begin
            tmr_cnt_nxt = (tmr_match && tmr_clr_on_match) ? 32'h0 : tmr_cnt + 32'd1;
        end
        if (wr_en && word_sel == OFF_TMR_CNT) begin
            tmr_cnt_nxt = io_data_write;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmr_cnt          <= 32'h0;
            tmr_cmp          <= 32'hFFFF_FFFF;
            tmr_en           <= 1'b0;
            tmr_clr_on_match <= 1'b0;
        end else begin
            tmr_cnt <= tmr_cnt_nxt;
            if (wr_en && word_sel == OFF_TMR_CMP) begin
                tmr_cmp <= io_data_write;
            end
            if (wr_en && word_sel == OFF_TMR_CTRL) begin
                tmr_en           <= io_data_write[0];
                tmr_clr_on_match <= io_data_write[1];
            end
        end
    end

    // Match wins over a write-1-clear landing in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending <= 1'b0;
        end else if (tmr_match) begin
            pending <= 1'b1;
        end else if (wr_en && word_sel == OFF_TMR_CTRL && io_data_write[8]) begin
            pending <= 1'b0;
        end
    end

    assign irq = pending;

    always_comb begin
        status                      = 32'h0;
        status[0]                   = fifo_full;
        status[1]                   = fifo_empty;
        status[2 +: CW]             = fifo_cnt;
        status[8]                   = pending;
        status[9]                   = ovf;
    end

    always_comb begin
        io_data_read = 32'h0;
        if (io_en && !io_we) begin
            case (word_sel)
                OFF_GPIO_OUT: io_data_read = gpio_out;
                OFF_GPIO_IN:  io_data_read = {24'h0, gpio_sync2};
                OFF_STATUS:   io_data_read = status;
                OFF_TMR_CNT:  io_data_read = tmr_cnt;
                OFF_TMR_CMP:  io_data_read = tmr_cmp;
                OFF_TMR_CTRL: io_data_read = {30'h0, tmr_clr_on_match, tmr_en};
                default:      io_data_read = 32'h0;
            endcase
        end
    end

endmodule
